mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse from E stage when a mult/multu/div/divu instruction is issued.
REQ-006 MDUop  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo.
REQ-007 A  input  32  rs operand, already forwarded.
REQ-008 B  input  32  rt operand, already forwarded.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 HI  output  32  architectural HI register, consumed by the E/M pipeline register.
REQ-011 LO  output  32  architectural LO register, consumed by the E/M pipeline register.

Function
REQ-012 The FSM SHALL have two states, IDLE and BUSY, plus a down-counter of width ceil(log2(max(MULT_CYCLES,DIV_CYCLES)+1)).
REQ-013 In IDLE, start=1 with MDUop in {001..100} SHALL latch A, B and MDUop, load the counter with the op's cycle count, and enter BUSY.
REQ-014 For start at edge t, busy SHALL be 1 for exactly N cycles (after edges t..t+N-1), and HI/LO SHALL take the new result at edge t+N, with busy=0 from then on.
REQ-015 HI and LO SHALL hold their previous values throughout BUSY; no partial results are visible.
REQ-016 mult: {HI,LO} SHALL equal the signed 64-bit product of the latched operands; multu: unsigned product.
REQ-017 div: LO SHALL be the signed quotient truncated toward zero, and HI SHALL be the remainder with the sign of the dividend; divu: unsigned quotient/remainder.
REQ-018 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 Divide by zero (B=0 for div/divu) SHALL still run DIV_CYCLES busy cycles and SHALL leave HI and LO unchanged.
REQ-020 In IDLE, MDUop=101 (mthi) SHALL write A into HI at the next edge, and 110 (mtlo) SHALL write A into LO, with busy unaffected; start is not required.
REQ-021 start, mthi and mtlo received while busy=1 SHALL be ignored (the hazard unit stalls them; they are not queued).
REQ-022 start=1 with MDUop in {000,101,110}, or MDUop=111, SHALL not enter BUSY; 101/110 behave as in REQ-020.
REQ-023 Result computation SHALL use only the latched operands, so changes on A/B during BUSY have no effect.
REQ-024 Back-to-back: a start in the first cycle where busy=0 after completion SHALL be accepted, and that cycle's HI/LO outputs SHALL already show the previous result.

Reset
REQ-025 reset=1 at an edge SHALL force state IDLE, counter 0, busy 0, HI 0 and LO 0, with latched operands cleared.
REQ-026 reset during BUSY SHALL discard the pending result; it never reaches HI/LO.
REQ-027 reset SHALL take priority over start, mthi and mtlo in the same cycle.

Structure
REQ-028 The MDUop encodings and the default MULT_CYCLES/DIV_CYCLES values SHALL live in the shared CPU constants package, which the decoder also uses.
REQ-029 The module SHALL be a single module with no sub-module; the product/quotient SHALL be computed behaviourally from latched operands at completion.
REQ-030 busy SHALL come directly from a register (no combinational path from start); the hazard unit forms its stall from start|busy.

Verification
REQ-031 mult A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> 10 busy cycles, HI/LO unchanged.
REQ-034 mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0, busy stays 0.
REQ-035 start div, then mtlo A=0x55 at busy cycle 3 and reset at busy cycle 6 -> mtlo has no effect; after reset busy=0, HI=LO=0, and no later update occurs.
REQ-036 mult 2*3 followed immediately by multu 4*5 on the first idle cycle -> LO=6 visible for exactly 5 cycles, then LO=20, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared CPU constants: MDU operation encodings and default multiply/divide latencies.
// Imported by the MDU and by the instruction decoder.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110,
    MDU_RSVD  = 3'b111
  } mdu_op_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic is_muldiv(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and committed in one step at completion.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_t          op_in, op_q;
  logic [31:0]      a_q, b_q;
  logic             issue, done;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sdiv_a, sdiv_b;
  logic [31:0]        udiv_b;
  logic [31:0]        res_hi, res_lo;
  logic               res_we;

  assign op_in = mdu_op_t'(MDUop);
  assign issue = (state_q == MDU_IDLE) && start && is_muldiv(op_in);
  assign done  = (state_q == MDU_BUSY) && (cnt_q == CNT_W'(1));

  // State register
  // NOTE: sequential state always uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  // NOTE: every comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (issue) begin
          state_d = MDU_BUSY;
          cnt_d   = ((op_in == MDU_DIV) || (op_in == MDU_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                                : CNT_W'(MULT_CYCLES);
        end
      end
      MDU_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // Outputs: busy comes straight from the state flop, never from start.
  always_comb begin
    busy = (state_q == MDU_BUSY);
  end

  // Result computation from latched operands only.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign sdiv_a = $signed(a_q);
  // A zero divisor never commits; substitute 1 so the divider never sees 0.
  assign udiv_b = (b_q == 32'd0) ? 32'd1 : b_q;
  assign sdiv_b = $signed(udiv_b);

  always_comb begin
    res_hi = HI;
    res_lo = LO;
    res_we = 1'b0;
    unique case (op_q)
      MDU_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_we           = 1'b1;
      end
      MDU_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_we           = 1'b1;
      end
      MDU_DIV: begin
        res_we = (b_q != 32'd0);
        if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = sdiv_a / sdiv_b;
          res_hi = sdiv_a % sdiv_b;
        end
      end
      MDU_DIVU: begin
        res_we = (b_q != 32'd0);
        res_lo = a_q / udiv_b;
        res_hi = a_q % udiv_b;
      end
      default: begin
        res_we = 1'b0;
      end
    endcase
  end

  // Operand latches and architectural HI/LO
  // NOTE: these are plain registers, not a memory, so all of them are cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= MDU_NONE;
      a_q  <= '0;
      b_q  <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if (issue) begin
        op_q <= op_in;
        a_q  <= A;
        b_q  <= B;
      end
      if (done) begin
        if (res_we) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end else if (state_q == MDU_IDLE) begin
        if (op_in == MDU_MTHI) HI <= A;
        if (op_in == MDU_MTLO) LO <= A;
      end
    end
  end

endmodule
